// File: rtl/rv_test_pkg.sv
// Shared types and ABI constants for the end-of-test monitor.
// s10 flags completion, s11 carries the pass/fail result.
package rv_test_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam int unsigned REG_S10 = 26;
    localparam int unsigned REG_S11 = 27;

    localparam logic [31:0] RESULT_PASS = 32'h1;
    localparam logic [31:0] DONE_MARK   = 32'h1;

endpackage

// File: rtl/rv_test_monitor.sv
// End-of-test monitor: snoops register write-back for s10/s11 and
// produces sticky done/pass/fail/timeout flags plus a cycle count.
module rv_test_monitor
    import rv_test_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned SETTLE_CYCLES  = 5,
    parameter int unsigned REG_DONE       = REG_S10,
    parameter int unsigned REG_RESULT     = REG_S11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_wdata_i,
    output logic        done_o,
    output logic        pass_o,
    output logic        fail_o,
    output logic        timeout_o,
    output logic [31:0] cycle_cnt_o
);

    localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [31:0] s10_q;
    logic [31:0] s11_q;
    logic [31:0] settle_cnt;
    logic [31:0] cycle_cnt;
    logic        done_q;
    logic        pass_q;
    logic        fail_q;
    logic        tmo_q;

    logic hit_done;
    logic hit_res;
    logic s10_set;
    logic tmo_hit;
    logic settled;

    // x0 is hardwired zero, so a write there can never be a real s10/s11.
    assign hit_done = wb_we_i && (wb_waddr_i != 5'd0)
                   && (wb_waddr_i == 5'(REG_DONE));
    assign hit_res  = wb_we_i && (wb_waddr_i != 5'd0)
                   && (wb_waddr_i == 5'(REG_RESULT));

    assign s10_set = (s10_q == DONE_MARK);
    assign tmo_hit = (cycle_cnt == TMO_LAST);
    assign settled = s10_set && (settle_cnt == SETTLE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            s10_q      <= '0;
            s11_q      <= '0;
            settle_cnt <= '0;
            cycle_cnt  <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            if (state != ST_DONE) begin
                if (hit_done) s10_q <= wb_wdata_i;
                if (hit_res)  s11_q <= wb_wdata_i;
                if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
            end
            unique case (state)
                ST_RUN: begin
                    if (tmo_hit) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                        fail_q <= 1'b1;
                        tmo_q  <= 1'b1;
                    end else if (s10_set) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    // A completed settle outranks a timeout on the same edge.
                    if (settled) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                        pass_q <= (s11_q == RESULT_PASS);
                        fail_q <= (s11_q != RESULT_PASS);
                    end else if (tmo_hit) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                        fail_q <= 1'b1;
                        tmo_q  <= 1'b1;
                    end else if (!s10_set) begin
                        state      <= ST_RUN;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 32'd1;
                    end
                end
                ST_DONE: ;
                default: state <= ST_RUN;
            endcase
        end
    end

    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign timeout_o   = tmo_q;
    assign cycle_cnt_o = cycle_cnt;

endmodule

// File: tb/tb_rv_test_monitor.sv
// Directed bench for rv_test_monitor with an expected-result queue
// filled at stimulus time and drained when done_o rises.
module tb_rv_test_monitor;

    localparam int TMO = 50;
    localparam int SET = 5;

    logic        clk;
    logic        rst;
    logic        wb_we_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        done_o;
    logic        pass_o;
    logic        fail_o;
    logic        timeout_o;
    logic [31:0] cycle_cnt_o;

    typedef struct {
        int          done_edge;
        logic        p;
        logic        f;
        logic        t;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp;
    int n_bad;
    int edge_n;

    rv_test_monitor #(
        .TIMEOUT_CYCLES(TMO),
        .SETTLE_CYCLES (SET),
        .REG_DONE      (26),
        .REG_RESULT    (27)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_we_i    (wb_we_i),
        .wb_waddr_i (wb_waddr_i),
        .wb_wdata_i (wb_wdata_i),
        .done_o     (done_o),
        .pass_o     (pass_o),
        .fail_o     (fail_o),
        .timeout_o  (timeout_o),
        .cycle_cnt_o(cycle_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("%s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        wb_we_i    = 1'b0;
        wb_waddr_i = '0;
        wb_wdata_i = '0;
        step();
        step();
        rst    = 1'b0;
        edge_n = 0;
    endtask

    task automatic wr(input int e, input logic [4:0] a,
                      input logic [31:0] d);
        while (edge_n < e - 1) step();
        wb_we_i    = 1'b1;
        wb_waddr_i = a;
        wb_wdata_i = d;
        step();
        wb_we_i    = 1'b0;
        wb_waddr_i = '0;
        wb_wdata_i = '0;
    endtask

    task automatic push(input int e, input logic p, input logic f,
                        input logic t, input int c);
        exp_t x;
        x.done_edge = e;
        x.p         = p;
        x.f         = f;
        x.t         = t;
        x.cyc       = 32'(c);
        exp_q.push_back(x);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int   k;
        exp_t x;
        k = 0;
        while (!done_o && k < budget) begin
            step();
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done_o), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            x = exp_q.pop_front();
            chk({tag, "_edge"}, 32'(edge_n), 32'(x.done_edge));
            chk({tag, "_pass"}, 32'(pass_o), 32'(x.p));
            chk({tag, "_fail"}, 32'(fail_o), 32'(x.f));
            chk({tag, "_tmo"},  32'(timeout_o), 32'(x.t));
            chk({tag, "_cyc"},  cycle_cnt_o, x.cyc);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        edge_n = 0;
        rst    = 1'b1;
        wb_we_i    = 1'b0;
        wb_waddr_i = '0;
        wb_wdata_i = '0;
        #3;
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_pass", 32'(pass_o), 32'd0);
        chk("rst_fail", 32'(fail_o), 32'd0);
        chk("rst_tmo",  32'(timeout_o), 32'd0);
        chk("rst_cyc",  cycle_cnt_o, 32'd0);

        // pass: s11 then s10
        do_reset();
        wr(20, 5'd27, 32'd1);
        wr(30, 5'd26, 32'd1);
        push(36, 1'b1, 1'b0, 1'b0, 36);
        wait_done("t1", 20);

        // fail: s11 = 0
        do_reset();
        wr(9, 5'd27, 32'd0);
        wr(10, 5'd26, 32'd1);
        push(16, 1'b0, 1'b1, 1'b0, 16);
        wait_done("t2", 20);

        // s10 rewritten during settle
        do_reset();
        wr(5, 5'd27, 32'd1);
        wr(10, 5'd26, 32'd1);
        wr(12, 5'd26, 32'd0);
        while (edge_n < 16) step();
        chk("t3_no_early_done", 32'(done_o), 32'd0);
        wr(20, 5'd26, 32'd1);
        push(26, 1'b1, 1'b0, 1'b0, 26);
        wait_done("t3", 20);

        // timeout, then counter hold
        do_reset();
        push(TMO, 1'b0, 1'b1, 1'b1, TMO);
        wait_done("t4", TMO + 10);
        for (int i = 0; i < 20; i++) step();
        chk("t4_cyc_hold", cycle_cnt_o, 32'(TMO));
        chk("t4_done_hold", 32'(done_o), 32'd1);
        chk("t4_tmo_hold", 32'(timeout_o), 32'd1);

        // x0 write ignored, s11 value to s10 address
        do_reset();
        wr(5, 5'd0, 32'd1);
        wr(10, 5'd26, 32'd1);
        push(16, 1'b0, 1'b1, 1'b0, 16);
        wait_done("t5", 20);

        // reset during settle
        do_reset();
        wr(10, 5'd26, 32'd1);
        while (edge_n < 13) step();
        chk("t6_cyc_pre", cycle_cnt_o, 32'd13);
        rst = 1'b1;
        #1;
        chk("t6_rst_done", 32'(done_o), 32'd0);
        chk("t6_rst_fail", 32'(fail_o), 32'd0);
        chk("t6_rst_cyc",  cycle_cnt_o, 32'd0);
        step();
        rst    = 1'b0;
        edge_n = 0;
        push(TMO, 1'b0, 1'b1, 1'b1, TMO);
        wait_done("t6", TMO + 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
